// File: rtl/data_memory.sv
// Word-addressed single-port 32-bit data RAM for the load/store path.
// Synchronous whole-word write, combinational read gated by rd_en, async clear on reset.
module data_memory #(
  parameter int DEPTH     = 256,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);

  logic [31:0]          r_mem [DEPTH];
  logic [ADDR_BITS-1:0] w_idx;
  logic                 w_unused_addr;

  // Byte offset and bits above the array are dropped, so accesses wrap modulo DEPTH*4.
  assign w_idx         = address[ADDR_BITS+1:2];
  assign w_unused_addr = &{1'b0, address[31:ADDR_BITS+2], address[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (wr_en) begin
      r_mem[w_idx] <= wdata;
    end
  end

  // No bypass: a same-cycle write is visible only after the edge.
  assign rdata = rd_en ? r_mem[w_idx] : 32'h0;

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory with hand-computed expectations.
module tb_data_memory;
  localparam int DEPTH = 256;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;

  int checks;
  int errors;

  data_memory #(.DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .rd_en  (rd_en),
    .address(address),
    .wdata  (wdata),
    .rdata  (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a;
    wdata   = d;
    wr_en   = 1'b1;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    address = a;
    rd_en   = 1'b1;
    #1;
    chk(tag, rdata, exp);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b1;
    address = 32'h0;
    wdata   = 32'h0;
    #12;
    chk("rst_high_rdata", rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    rd("reset_rd0", 32'h00, 32'h0);

    // Basic writes with rd_en low
    rd_en = 1'b0;
    wr(32'h04, 32'hA5A5A5A5);
    wr(32'h10, 32'h12345678);
    rd("rd_04", 32'h04, 32'hA5A5A5A5);
    rd("rd_10", 32'h10, 32'h12345678);

    // wr_en low must not store
    @(negedge clk);
    address = 32'h20;
    wdata   = 32'hDEADBEEF;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    @(posedge clk);
    rd("no_wr_20", 32'h20, 32'h0);

    // Read gating
    @(negedge clk);
    address = 32'h04;
    rd_en   = 1'b0;
    #1;
    chk("rden0_gate", rdata, 32'h0);
    rd_en = 1'b1;
    #1;
    chk("rden1_same_cyc", rdata, 32'hA5A5A5A5);

    // Aliasing: byte offset and wrap
    wr(32'h04, 32'h11111111);
    rd("alias_05", 32'h05, 32'h11111111);
    rd("alias_06", 32'h06, 32'h11111111);
    rd("alias_07", 32'h07, 32'h11111111);
    rd("wrap_depth", 32'h04 + DEPTH*4, 32'h11111111);
    rd("wrap_hi_bits", 32'hFFFFFC04, 32'h11111111);

    // Top word and wrap past the end
    wr(32'h3FC, 32'hCAFEF00D);
    rd("top_word", 32'h3FC, 32'hCAFEF00D);
    rd("past_top_wraps_0", 32'h400, 32'h0);

    // Read during write, same address: old before edge, new after
    @(negedge clk);
    address = 32'h10;
    wdata   = 32'h55AA55AA;
    rd_en   = 1'b1;
    wr_en   = 1'b1;
    #1;
    chk("rdw_old", rdata, 32'h12345678);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    chk("rdw_new", rdata, 32'h55AA55AA);

    // Async reset between edges
    @(negedge clk);
    address = 32'h04;
    rd_en   = 1'b1;
    #1;
    chk("pre_rst_04", rdata, 32'h11111111);
    rst = 1'b1;
    #1;
    chk("async_rst_04", rdata, 32'h0);
    address = 32'h10;
    #1;
    chk("async_rst_10", rdata, 32'h0);

    // Write on an edge while reset is high is discarded
    @(negedge clk);
    address = 32'h08;
    wdata   = 32'hBADC0FFE;
    wr_en   = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    chk("wr_during_rst", rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    rd("post_rst_04", 32'h04, 32'h0);
    rd("post_rst_10", 32'h10, 32'h0);
    rd("post_rst_08", 32'h08, 32'h0);
    rd("post_rst_top", 32'h3FC, 32'h0);

    // First write after deassertion lands
    wr(32'h08, 32'h0F0F0F0F);
    rd("post_rst_wr", 32'h08, 32'h0F0F0F0F);
    rd("post_rst_neighbor", 32'h0C, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    $fatal(1);
  end
endmodule

// File: doc/data_memory.md
# data_memory

Word-addressed, single-port 32-bit data RAM for the RV core's load/store path. It takes a synchronous write on the rising clock edge and gives a combinational read gated by a read enable. All contents clear to zero on reset. It sits behind the core's memory stage: the LSU drives the byte address and the enables, and receives `rdata`.

## Interface
Parameters:
- `DEPTH`, default 256: number of 32-bit words. Must be a power of two, at least 4.
- `ADDR_BITS`, default $clog2(DEPTH): word-index width. This is derived; do not override it.

Ports:
- `clk`, input, 1: the single clock. All writes happen on its rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `wr_en`, input, 1: write enable, sampled on the rising edge of `clk`.
- `rd_en`, input, 1: read enable, combinational.
- `address`, input, 32: byte address.
- `wdata`, input, 32: write data.
- `rdata`, output, 32: read data.

## Operation
- Storage is `DEPTH` words × 32 bits.
- Word index = `address[ADDR_BITS+1:2]`.
  - `address[1:0]` is ignored. Misaligned addresses access the containing word; there is no error.
  - Bits above `ADDR_BITS+1` are ignored, so addresses wrap modulo `DEPTH*4`. There is no fault.
- Reset:
  - While `rst` is high, every word is forced to 0, asynchronously and immediately.
  - Writes are blocked while `rst` is high.
- Write:
  - On a rising edge of `clk` with `rst` low and `wr_en` high, `mem[index]` receives `wdata`.
  - Only whole-word writes are supported; there are no byte or half-word strobes.
  - If `wr_en` is low, memory is unchanged, whatever `wdata` and `address` hold.
- Read:
  - `rdata` = `mem[index]` when `rd_en` is high, else 32'h0.
  - It is purely combinational from `rd_en`, `address` and the memory contents.
- `wr_en` and `rd_en` are independent and may both be high.
  - Same address in the same cycle: `rdata` shows the old word until the edge, then the new word. There is no write-through bypass before the edge.
- No state machine. No handshake: every access completes in the cycle it is presented.

## Timing
- Reset value of `rdata`:
  - 0, since all words are 0.
  - While `rst` is high, `rdata` = 0 whatever `rd_en` is, because the contents are 0.
- Write latency: data is stored at the rising edge where `wr_en` is high. It is readable combinationally immediately after that edge.
- Read latency: 0 cycles, with combinational settle only.
- Reset deasserted mid-operation: the first write takes effect at the first rising edge where `rst` is low.
- Reset asserted mid-operation: contents clear immediately. A write on an edge coincident with `rst` high is discarded.
- Inputs must be stable around the rising edge of `clk`. There are no other constraints.

## Test plan
- Reset, then `rd_en`=1, `address`=0x00 → `rdata`=0x00000000.
- Write 0xA5A5A5A5 @0x04 and 0x12345678 @0x10 (one cycle each, `rd_en`=0). Then read @0x04 → 0xA5A5A5A5, and read @0x10 → 0x12345678.
- `wr_en`=0, `wdata`=0xDEADBEEF, `address`=0x20 for one cycle. Then read @0x20 → 0x00000000.
- `rd_en`=0 with `address`=0x04 holding 0xA5A5A5A5 → `rdata`=0. Raise `rd_en` → 0xA5A5A5A5 in the same cycle.
- Aliasing:
  - Write 0x11111111 @0x04, then read @0x05, 0x06 and 0x07 → all 0x11111111.
  - Read @(0x04 + DEPTH*4) → 0x11111111 (wrap).
- Assert `rst` asynchronously between edges after writes → `rdata` reads 0 at @0x04 and @0x10 at once, and after deassertion.
